// File: rtl/otter_crypto_engine.sv
// otter_crypto_engine: multi-cycle Feistel block-cipher coprocessor for the OTTER MCU.
// Operands are captured on an accepted start. UNROLL rounds run per RUN cycle, and
// the final {L,R} appears on result together with a one-cycle done pulse.
module otter_crypto_engine #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ROUNDS = 16,
  parameter int unsigned UNROLL = 1
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             start,
  input  logic             mode,
  input  logic             clear,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] key,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned H     = WIDTH / 2;
  localparam int unsigned RW    = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam int unsigned ROT_F = 3 % H;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [H-1:0]     r_l;
  logic [H-1:0]     r_r;
  logic [WIDTH-1:0] r_key;
  logic             r_mode;
  logic [RW-1:0]    r_idx;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;

  logic [H-1:0]     w_kx;
  logic [H-1:0]     w_l_nxt;
  logic [H-1:0]     w_r_nxt;
  logic             w_last;
  logic [RW-1:0]    w_idx_nxt;

  // Rotate left by s (s < H), built from a doubled word so that s=0 is a pass-through.
  function automatic logic [H-1:0] rotl(input logic [H-1:0] x, input int unsigned s);
    logic [2*H-1:0] d;
    d = {x, x} << s;
    return d[2*H-1:H];
  endfunction

  // Round key for round index r: folded key rotated by r mod H, then offset by r.
  function automatic logic [H-1:0] round_key(input logic [H-1:0] kx, input int unsigned r);
    return rotl(kx, r % H) + H'(r);
  endfunction

  // Round function: F(x,k) = rotl(x,3) ^ (x + k), all mod 2^H.
  function automatic logic [H-1:0] f_round(input logic [H-1:0] x, input logic [H-1:0] k);
    return rotl(x, ROT_F) ^ (x + k);
  endfunction

  assign w_kx = r_key[H-1:0] ^ r_key[WIDTH-1:H];

  // Final RUN cycle: the last round of this cycle is round ROUNDS-1 (enc) or round 0 (dec).
  assign w_last    = r_mode ? (32'(r_idx) == UNROLL - 1)
                            : (32'(r_idx) + UNROLL == ROUNDS);
  assign w_idx_nxt = r_mode ? (r_idx - RW'(UNROLL)) : (r_idx + RW'(UNROLL));

  // Unrolled datapath: UNROLL consecutive rounds starting at the current round index.
  always_comb begin : round_path
    logic [H-1:0] l_v;
    logic [H-1:0] r_v;
    logic [H-1:0] k_v;
    int unsigned  ri;
    l_v = r_l;
    r_v = r_r;
    k_v = '0;
    ri  = 0;
    for (int unsigned u = 0; u < UNROLL; u++) begin
      ri  = r_mode ? (32'(r_idx) - u) : (32'(r_idx) + u);
      k_v = round_key(w_kx, ri);
      if (r_mode) begin
        {l_v, r_v} = {r_v ^ f_round(l_v, k_v), l_v};
      end else begin
        {l_v, r_v} = {r_v, l_v ^ f_round(r_v, k_v)};
      end
    end
    w_l_nxt = l_v;
    w_r_nxt = r_v;
  end

  // Control FSM with registered busy/done/result; clear outranks start.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state  <= S_IDLE;
      r_l      <= '0;
      r_r      <= '0;
      r_key    <= '0;
      r_mode   <= 1'b0;
      r_idx    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      if (clear) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (start) begin
              r_l     <= data_in[WIDTH-1:H];
              r_r     <= data_in[H-1:0];
              r_key   <= key;
              r_mode  <= mode;
              r_idx   <= mode ? RW'(ROUNDS - 1) : '0;
              r_busy  <= 1'b1;
              r_state <= S_RUN;
            end else begin
              r_state <= S_IDLE;
            end
          end
          S_RUN: begin
            r_l <= w_l_nxt;
            r_r <= w_r_nxt;
            if (w_last) begin
              r_result <= {w_l_nxt, w_r_nxt};
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_idx <= w_idx_nxt;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule
